// File: rtl/hv_bist_seq.sv
// HV-side BIST sequencer: drives one bisthv_* stimulus at a time, waits for the matching detector to respond,
// then waits for it to clear, and records a per-check fail bit. Outputs decode registered state/index.
module hv_bist_seq #(
  parameter int         TMO_CYC    = 200,
  parameter int         SETTLE_CYC = 16,
  parameter logic [9:0] ADC_LO     = 10'd100,
  parameter logic [9:0] ADC_HI     = 10'd900
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bist_start,
  input  logic       bist_abort,
  input  logic [5:0] bist_mask,
  input  logic       ov_vcc,
  input  logic       otp,
  input  logic       desat_fault,
  input  logic       ocp_fault,
  input  logic       scp_fault,
  input  logic       adc_ready1,
  input  logic [9:0] adc_data1,
  output logic       bisthv_ov,
  output logic       bisthv_ot,
  output logic       bisthv_desat,
  output logic       bisthv_oc,
  output logic       bisthv_sc,
  output logic       bisthv_adc,
  output logic       bist_busy,
  output logic       bist_done,
  output logic       bist_pass,
  output logic [5:0] bist_fail_vec
);

  localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST    = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [2:0]    LAST_IDX    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    RELEASE = 3'd2,
    NEXT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [5:0]    fail_q, fail_d;
  logic          pass_q, pass_d;

  logic [5:0]    resp_vec;
  logic          resp;
  logic          adc_ok;
  logic [2:0]    idx_nxt;
  logic [CW-1:0] tmo_inc;
  logic [CW-1:0] settle_inc;

  assign resp_vec   = {adc_ready1, scp_fault, ocp_fault, desat_fault, otp, ov_vcc};
  assign resp       = resp_vec[idx_q];
  assign adc_ok     = (adc_data1 >= ADC_LO) && (adc_data1 <= ADC_HI);
  assign idx_nxt    = idx_q + 3'd1;
  // Saturating counters: a stuck counter must never wrap back into a window that looks valid.
  assign tmo_inc    = (tmo_q == CNT_MAX) ? tmo_q : tmo_q + 1'b1;
  assign settle_inc = (settle_q == CNT_MAX) ? settle_q : settle_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      tmo_q    <= '0;
      settle_q <= '0;
      fail_q   <= 6'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      settle_q <= settle_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    settle_d = settle_q;
    fail_d   = fail_q;
    pass_d   = pass_q;

    case (state_q)
      IDLE: begin
        tmo_d    = '0;
        settle_d = '0;
        if (bist_start) begin
          fail_d  = 6'd0;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          state_d = bist_mask[0] ? NEXT : DRIVE;
        end
      end

      DRIVE: begin
        tmo_d = tmo_inc;
        // A response arriving on the timeout cycle still counts as a pass.
        if (resp) begin
          if ((idx_q == LAST_IDX) && !adc_ok) begin
            fail_d[idx_q] = 1'b1;
          end
          state_d  = RELEASE;
          tmo_d    = '0;
          settle_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          fail_d[idx_q] = 1'b1;
          state_d       = RELEASE;
          tmo_d         = '0;
          settle_d      = '0;
        end
      end

      RELEASE: begin
        tmo_d    = tmo_inc;
        settle_d = resp ? '0 : settle_inc;
        if (!resp && (settle_q == SETTLE_LAST)) begin
          state_d  = NEXT;
          tmo_d    = '0;
          settle_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          fail_d[idx_q] = 1'b1;
          state_d       = NEXT;
          tmo_d         = '0;
          settle_d      = '0;
        end
      end

      NEXT: begin
        tmo_d    = '0;
        settle_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          pass_d  = (fail_q == 6'd0);
        end else begin
          idx_d = idx_nxt;
          if (!bist_mask[idx_nxt]) begin
            state_d = DRIVE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every other transition and freezes the partial result.
    if ((state_q != IDLE) && bist_abort) begin
      state_d  = IDLE;
      idx_d    = idx_q;
      tmo_d    = '0;
      settle_d = '0;
      fail_d   = fail_q;
      pass_d   = pass_q;
    end
  end

  logic [5:0] stim_vec;
  assign stim_vec = (state_q == DRIVE) ? (6'd1 << idx_q) : 6'd0;

  assign bisthv_ov     = stim_vec[0];
  assign bisthv_ot     = stim_vec[1];
  assign bisthv_desat  = stim_vec[2];
  assign bisthv_oc     = stim_vec[3];
  assign bisthv_sc     = stim_vec[4];
  assign bisthv_adc    = stim_vec[5];
  assign bist_busy     = (state_q != IDLE);
  assign bist_done     = (state_q == DONE);
  assign bist_pass     = pass_q;
  assign bist_fail_vec = fail_q;

endmodule
